// File: rtl/bpc_decode_ctrl.sv
// Sequencer for the 4-lane BPC symbol decoder group: owns the code buffer, its fill
// count and zero-run state, refills from the compressed stream and tags planes.
module bpc_decode_ctrl #(
    parameter int IN_W   = 32,
    parameter int PLANES = 33
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [IN_W-1:0] in_data,
    input  logic            in_valid,
    input  logic            in_last,
    output logic            in_ready,
    output logic [127:0]    grp_code_buf,
    output logic [6:0]      grp_buf_size,
    output logic [3:0]      grp_zrl_cnt,
    input  logic [127:0]    grp_code_buf_o,
    input  logic [6:0]      grp_buf_size_o,
    input  logic [3:0]      grp_zrl_cnt_o,
    input  logic [251:0]    grp_data,
    input  logic [3:0]      grp_valid,
    input  logic [3:0]      grp_xor,
    output logic [251:0]    out_data,
    output logic [3:0]      out_valid,
    output logic [3:0]      out_xor,
    output logic [23:0]     out_idx,
    output logic [3:0]      out_last,
    input  logic            out_ready,
    output logic            busy,
    output logic            done
);

    localparam logic [6:0] FILL_MAX = 7'(127 - IN_W);
    localparam logic [6:0] IN_W7    = 7'(IN_W);
    localparam logic [6:0] PLANES7  = 7'(PLANES);
    localparam logic [5:0] LAST_IDX = 6'(PLANES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t         state_q;
    logic [127:0]   code_q;
    logic [6:0]     size_q;
    logic [3:0]     zrl_q;
    logic [5:0]     idx_q;
    logic           last_seen_q;
    logic           done_q;

    logic           adv;
    logic           accept;
    logic [127:0]   base;
    logic [127:0]   word_al;
    logic [127:0]   code_nxt;
    logic [6:0]     bsz;
    logic [6:0]     size_nxt;

    // Step is at most 4 and base < PLANES, so one conditional subtract wraps it.
    function automatic logic [5:0] wrap_idx(input logic [5:0] b, input logic [2:0] step);
        logic [6:0] s;
        s = {1'b0, b} + {4'b0, step};
        if (s >= PLANES7) s = s - PLANES7;
        return s[5:0];
    endfunction

    function automatic logic [2:0] lane_count(input logic [3:0] v);
        return 3'(v[3]) + 3'(v[2]) + 3'(v[1]) + 3'(v[0]);
    endfunction

    assign adv      = (state_q != IDLE) && (out_ready || (grp_valid == 4'b0));
    assign base     = adv ? grp_code_buf_o : code_q;
    assign bsz      = adv ? grp_buf_size_o : size_q;
    assign in_ready = (state_q == RUN) && (bsz <= FILL_MAX);
    assign accept   = in_valid && in_ready;
    assign word_al  = {in_data, {(128-IN_W){1'b0}}};
    assign code_nxt = accept ? (base | (word_al >> bsz)) : base;
    assign size_nxt = accept ? (bsz + IN_W7) : bsz;

    assign grp_code_buf = code_q;
    assign grp_buf_size = size_q;
    assign grp_zrl_cnt  = zrl_q;
    assign out_data     = grp_data;
    assign out_xor      = grp_xor;
    assign out_valid    = (state_q != IDLE) ? grp_valid : 4'b0;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;

    always_comb begin
        out_idx  = '0;
        out_last = '0;
        for (int k = 0; k < 4; k++) begin
            out_idx[23-6*k -: 6] = wrap_idx(idx_q, 3'(k));
            out_last[3-k]        = (wrap_idx(idx_q, 3'(k)) == LAST_IDX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            code_q      <= '0;
            size_q      <= '0;
            zrl_q       <= '0;
            idx_q       <= '0;
            last_seen_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        code_q      <= '0;
                        size_q      <= '0;
                        zrl_q       <= '0;
                        idx_q       <= '0;
                        last_seen_q <= 1'b0;
                        state_q     <= RUN;
                    end
                end
                RUN, DRAIN: begin
                    if (adv) begin
                        zrl_q <= grp_zrl_cnt_o;
                        idx_q <= wrap_idx(idx_q, lane_count(grp_valid));
                    end
                    code_q <= code_nxt;
                    size_q <= size_nxt;
                    if (state_q == RUN) begin
                        if (accept && in_last) begin
                            last_seen_q <= 1'b1;
                            state_q     <= DRAIN;
                        end
                    end else if (!grp_valid[3] && (zrl_q == 4'd0)) begin
                        // Whatever is left in the buffer is stream padding.
                        code_q  <= '0;
                        size_q  <= '0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bpc_decode_ctrl.sv
// Bench for bpc_decode_ctrl: a stand-in byte-symbol decoder group drives the grp_* side,
// expected planes come from a per-stream symbol model and are checked from a queue.
module tb_bpc_decode_ctrl;

    localparam int IN_W   = 32;
    localparam int PLANES = 33;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [IN_W-1:0] in_data;
    logic            in_valid;
    logic            in_last;
    logic            in_ready;
    logic [127:0]    grp_code_buf;
    logic [6:0]      grp_buf_size;
    logic [3:0]      grp_zrl_cnt;
    logic [127:0]    grp_code_buf_o;
    logic [6:0]      grp_buf_size_o;
    logic [3:0]      grp_zrl_cnt_o;
    logic [251:0]    grp_data;
    logic [3:0]      grp_valid;
    logic [3:0]      grp_xor;
    logic [251:0]    out_data;
    logic [3:0]      out_valid;
    logic [3:0]      out_xor;
    logic [23:0]     out_idx;
    logic [3:0]      out_last;
    logic            out_ready;
    logic            busy;
    logic            done;

    bpc_decode_ctrl #(.IN_W(IN_W), .PLANES(PLANES)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .grp_code_buf(grp_code_buf), .grp_buf_size(grp_buf_size), .grp_zrl_cnt(grp_zrl_cnt),
        .grp_code_buf_o(grp_code_buf_o), .grp_buf_size_o(grp_buf_size_o),
        .grp_zrl_cnt_o(grp_zrl_cnt_o), .grp_data(grp_data), .grp_valid(grp_valid),
        .grp_xor(grp_xor), .out_data(out_data), .out_valid(out_valid), .out_xor(out_xor),
        .out_idx(out_idx), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Stand-in decoder group: 8-bit symbols. 0xFn = zero plane plus n more zero planes
    // (xor=1); any other byte b = plane with data b and xor b[0].
    logic [127:0] fc;
    int           fsz;
    int           fz;
    logic [7:0]   fch;
    logic         fstop;
    always_comb begin
        grp_valid = '0;
        grp_xor   = '0;
        grp_data  = '0;
        fc        = grp_code_buf;
        fsz       = int'(grp_buf_size);
        fz        = int'(grp_zrl_cnt);
        fch       = '0;
        fstop     = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!fstop) begin
                if (fz > 0) begin
                    grp_valid[3-k] = 1'b1;
                    grp_xor[3-k]   = 1'b1;
                    fz             = fz - 1;
                end else if (fsz >= 8) begin
                    fch            = fc[127:120];
                    fc             = fc << 8;
                    fsz            = fsz - 8;
                    grp_valid[3-k] = 1'b1;
                    if (fch[7:4] == 4'hF) begin
                        grp_xor[3-k] = 1'b1;
                        fz           = int'(fch[3:0]);
                    end else begin
                        grp_data[251-63*k -: 63] = {55'b0, fch};
                        grp_xor[3-k]             = fch[0];
                    end
                end else begin
                    fstop = 1'b1;
                end
            end
        end
        grp_code_buf_o = fc;
        grp_buf_size_o = 7'(fsz);
        grp_zrl_cnt_o  = 4'(fz);
    end

    typedef struct packed {
        logic [62:0] data;
        logic        x;
        logic [5:0]  idx;
        logic        last;
    } plane_t;

    plane_t exp_q[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    int     pcount;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    endtask

    task automatic push_plane(input logic [62:0] d, input logic x);
        plane_t p;
        p.data = d;
        p.x    = x;
        p.idx  = 6'(pcount % PLANES);
        p.last = ((pcount % PLANES) == PLANES - 1);
        exp_q.push_back(p);
        pcount++;
    endtask

    // Reference: each byte of the stream is one symbol, planes numbered modulo PLANES.
    task automatic model_word(input logic [31:0] w);
        logic [7:0] b;
        for (int i = 3; i >= 0; i--) begin
            b = w[8*i +: 8];
            if (b[7:4] == 4'hF) begin
                for (int r = 0; r <= int'(b[3:0]); r++) push_plane(63'd0, 1'b1);
            end else begin
                push_plane({55'd0, b}, b[0]);
            end
        end
    endtask

    function automatic logic [7:0] rand_sym();
        if ($urandom_range(0, 5) == 0) return {4'hF, 4'($urandom_range(0, 15))};
        return 8'($urandom_range(0, 239));
    endfunction

    // Monitor: every lane accepted by the sink is popped and compared.
    plane_t mp;
    plane_t ma;
    always @(negedge clk) begin
        if (rst_n && out_ready) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[3-k]) begin
                    ma.data = out_data[251-63*k -: 63];
                    ma.x    = out_xor[3-k];
                    ma.idx  = out_idx[23-6*k -: 6];
                    ma.last = out_last[3-k];
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL plane_extra lane=%0d actual=%0h expected=none", k, ma);
                    end else begin
                        mp = exp_q.pop_front();
                        chk("plane", 128'(ma), 128'(mp));
                    end
                end
            end
        end
    end

    // Sink backpressure: mostly ready, with occasional multi-cycle stalls.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 15) == 0) begin
                out_ready = 1'b0;
                repeat ($urandom_range(3, 8)) @(posedge clk);
                #1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send_words(input int n, input bit stray_start);
        logic [31:0] w;
        bit          ok;
        for (int i = 0; i < n; i++) begin
            w = {rand_sym(), rand_sym(), rand_sym(), rand_sym()};
            model_word(w);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            in_data  = w;
            in_last  = (i == n - 1);
            in_valid = 1'b1;
            start    = stray_start && (i == n / 2);
            ok       = 1'b0;
            for (int c = 0; c < 500; c++) begin
                @(negedge clk);
                if (in_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                n_checks++;
                $display("FAIL in_ready_timeout word=%0d actual=0 expected=1", i);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            start    = 1'b0;
        end
    endtask

    task automatic pulse_start();
        pcount = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_stream(input int n, input bit stray_start);
        bit seen;
        pulse_start();
        send_words(n, stray_start);
        seen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 128'(seen), 128'(1));
        chk("busy_at_done", 128'(busy), 128'(0));
        chk("planes_left", 128'(exp_q.size()), 128'(0));
        @(negedge clk);
        chk("done_one_cycle", 128'(done), 128'(0));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_in_ready"}, 128'(in_ready), 128'(0));
        chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_done"}, 128'(done), 128'(0));
        chk({tag, "_code"}, grp_code_buf, 128'(0));
        chk({tag, "_size"}, 128'(grp_buf_size), 128'(0));
        chk({tag, "_zrl"}, 128'(grp_zrl_cnt), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        #12;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Words offered while idle must not be taken.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("idle_in_ready", 128'(in_ready), 128'(0));
        chk("idle_busy", 128'(busy), 128'(0));
        @(posedge clk);
        #1 in_valid = 1'b0;

        run_stream(12, 1'b0);
        run_stream(20, 1'b1);
        for (int s = 0; s < 4; s++) run_stream($urandom_range(1, 16), 1'b0);

        // Asynchronous reset while draining.
        pulse_start();
        send_words(10, 1'b0);
        chk("drain_busy", 128'(busy), 128'(1));
        chk("drain_in_ready", 128'(in_ready), 128'(0));
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_stream(12, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
